// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU.
// Holds registered operands for a settle time, captures the result and returns it tagged by requester.
module alu_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_opcode,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_opcode,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic [3:0] rsp_flags,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_next;
    logic       last_grant;
    logic       winner;
    logic       accept;
    logic [3:0] settle_cnt;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        winner = 1'b0;
        unique case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase

        // Ready is suppressed while reset is held, even though state already reads IDLE.
        req_ready = 2'b00;
        if (!rst && state == IDLE && req_valid != 2'b00)
            req_ready[winner] = 1'b1;
    end

    assign accept = (req_valid & req_ready) != 2'b00;
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)             state_next = ISSUE;
            ISSUE:   if (settle_cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready)          state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_out    <= 4'd0;
            rsp_flags  <= 4'd0;
            settle_cnt <= 4'd0;
            op_count   <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_opcode <= winner ? req1_opcode : req0_opcode;
                        alu_a      <= winner ? req1_a      : req0_a;
                        alu_b      <= winner ? req1_b      : req0_b;
                        last_grant <= winner;
                        rsp_id     <= winner;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ISSUE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_out   <= alu_out;
                        rsp_flags <= alu_flags;
                        rsp_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with SETTLE_CYCLES=1, one with 3.
// Instance 1 sees a combinational adder as its ALU; instance 2's ALU output is driven by hand.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance 1 (SETTLE_CYCLES = 1) ----------------
    logic       rst1, busy1, rsp_valid1, rsp_ready1, rsp_id1;
    logic [1:0] req_valid1, req_ready1;
    logic [3:0] req0_opcode1, req0_a1, req0_b1, req1_opcode1, req1_a1, req1_b1;
    logic [3:0] alu_opcode1, alu_a1, alu_b1, alu_out1, alu_flags1, rsp_out1, rsp_flags1;
    logic [7:0] op_count1;
    logic [4:0] sum1;

    // ALU model: out = A+B, flags {P,V,C,Z} = {0,0,carry,zero}.
    always_comb begin
        sum1       = {1'b0, alu_a1} + {1'b0, alu_b1};
        alu_out1   = sum1[3:0];
        alu_flags1 = {2'b00, sum1[4], sum1[3:0] == 4'd0};
    end

    alu_share_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req0_opcode(req0_opcode1), .req0_a(req0_a1), .req0_b(req0_b1),
        .req1_opcode(req1_opcode1), .req1_a(req1_a1), .req1_b(req1_b1),
        .alu_opcode(alu_opcode1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_out(alu_out1), .alu_flags(alu_flags1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
        .rsp_out(rsp_out1), .rsp_flags(rsp_flags1),
        .busy(busy1), .op_count(op_count1)
    );

    // ---------------- instance 2 (SETTLE_CYCLES = 3) ----------------
    logic       rst2, busy2, rsp_valid2, rsp_ready2, rsp_id2;
    logic [1:0] req_valid2, req_ready2;
    logic [3:0] req0_opcode2, req0_a2, req0_b2, req1_opcode2, req1_a2, req1_b2;
    logic [3:0] alu_opcode2, alu_a2, alu_b2, alu_out2, alu_flags2, rsp_out2, rsp_flags2;
    logic [7:0] op_count2;

    alu_share_arbiter #(.SETTLE_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst2),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req0_opcode(req0_opcode2), .req0_a(req0_a2), .req0_b(req0_b2),
        .req1_opcode(req1_opcode2), .req1_a(req1_a2), .req1_b(req1_b2),
        .alu_opcode(alu_opcode2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_out(alu_out2), .alu_flags(alu_flags2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
        .rsp_out(rsp_out2), .rsp_flags(rsp_flags2),
        .busy(busy2), .op_count(op_count2)
    );

    typedef struct {
        logic       id;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic [3:0] flags;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_cnt1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Hand-computed against the adder model above.
        vecs[0] = '{1'b0, 4'b0100, 4'd3,  4'd4,  4'd7,  4'b0000};
        vecs[1] = '{1'b0, 4'b0001, 4'd9,  4'd7,  4'd0,  4'b0011};
        vecs[2] = '{1'b1, 4'b0010, 4'd15, 4'd15, 4'hE,  4'b0010};
        vecs[3] = '{1'b0, 4'b1111, 4'd0,  4'd0,  4'd0,  4'b0001};
        vecs[4] = '{1'b1, 4'b0011, 4'd5,  4'd6,  4'hB,  4'b0000};

        rst1 = 1'b1; rst2 = 1'b1;
        req_valid1 = 2'b11; rsp_ready1 = 1'b0;
        req0_opcode1 = 4'd0; req0_a1 = 4'd0; req0_b1 = 4'd0;
        req1_opcode1 = 4'd0; req1_a1 = 4'd0; req1_b1 = 4'd0;
        req_valid2 = 2'b00; rsp_ready2 = 1'b0;
        req0_opcode2 = 4'd0; req0_a2 = 4'd0; req0_b2 = 4'd0;
        req1_opcode2 = 4'd0; req1_a2 = 4'd0; req1_b2 = 4'd0;
        alu_out2 = 4'd0; alu_flags2 = 4'd0;
        exp_cnt1 = 8'd0;
        #3;

        // ---- reset values ----
        check("rst_req_ready", req_ready1, 2'b00);
        check("rst_alu_opcode", alu_opcode1, 0);
        check("rst_alu_a", alu_a1, 0);
        check("rst_alu_b", alu_b1, 0);
        check("rst_rsp_valid", rsp_valid1, 0);
        check("rst_rsp_id", rsp_id1, 0);
        check("rst_rsp_out", rsp_out1, 0);
        check("rst_rsp_flags", rsp_flags1, 0);
        check("rst_busy", busy1, 0);
        check("rst_op_count", op_count1, 0);
        req_valid1 = 2'b00;
        @(negedge clk); rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // ---- table-driven single-requester operations ----
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].id == 1'b0) begin
                req0_opcode1 = vecs[i].op; req0_a1 = vecs[i].a; req0_b1 = vecs[i].b;
                req_valid1 = 2'b01;
            end else begin
                req1_opcode1 = vecs[i].op; req1_a1 = vecs[i].a; req1_b1 = vecs[i].b;
                req_valid1 = 2'b10;
            end
            #1 check($sformatf("v%0d_req_ready", i), req_ready1, vecs[i].id ? 2'b10 : 2'b01);
            @(negedge clk);
            req_valid1 = 2'b00;
            check($sformatf("v%0d_alu_opcode", i), alu_opcode1, vecs[i].op);
            check($sformatf("v%0d_alu_a", i), alu_a1, vecs[i].a);
            check($sformatf("v%0d_alu_b", i), alu_b1, vecs[i].b);
            check($sformatf("v%0d_busy", i), busy1, 1);
            check($sformatf("v%0d_early_valid", i), rsp_valid1, 0);
            @(negedge clk);
            check($sformatf("v%0d_rsp_valid", i), rsp_valid1, 1);
            check($sformatf("v%0d_rsp_id", i), rsp_id1, vecs[i].id);
            check($sformatf("v%0d_rsp_out", i), rsp_out1, vecs[i].out);
            check($sformatf("v%0d_rsp_flags", i), rsp_flags1, vecs[i].flags);
            rsp_ready1 = 1'b1;
            @(negedge clk);
            rsp_ready1 = 1'b0;
            exp_cnt1 = exp_cnt1 + 8'd1;
            check($sformatf("v%0d_rsp_clear", i), rsp_valid1, 0);
            check($sformatf("v%0d_idle", i), busy1, 0);
            check($sformatf("v%0d_op_count", i), op_count1, exp_cnt1);
        end

        // ---- round-robin with both requesters always valid (last grant was 1) ----
        req0_opcode1 = 4'd1; req0_a1 = 4'd1; req0_b1 = 4'd2;
        req1_opcode1 = 4'd2; req1_a1 = 4'd4; req1_b1 = 4'd8;
        req_valid1 = 2'b11; rsp_ready1 = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            check("rr_ready_onehot", req_ready1 == 2'b11, 0);
            if (rsp_valid1) begin
                check($sformatf("rr%0d_rsp_id", n), rsp_id1, n % 2);
                check($sformatf("rr%0d_rsp_out", n), rsp_out1, (n % 2) ? 4'hC : 4'h3);
                n++;
                if (n == 4) req_valid1 = 2'b00;
            end
        end
        check("rr_responses", n, 4);
        @(negedge clk);
        rsp_ready1 = 1'b0;
        exp_cnt1 = exp_cnt1 + 8'd4;
        check("rr_op_count", op_count1, exp_cnt1);

        // ---- response backpressure for 5 cycles ----
        req0_opcode1 = 4'd3; req0_a1 = 4'd5; req0_b1 = 4'd6;
        req_valid1 = 2'b01;
        @(negedge clk);
        req_valid1 = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), rsp_valid1, 1);
            check($sformatf("bp%0d_rsp_out", k), rsp_out1, 4'hB);
            check($sformatf("bp%0d_rsp_flags", k), rsp_flags1, 4'b0000);
            check($sformatf("bp%0d_rsp_id", k), rsp_id1, 0);
            check($sformatf("bp%0d_alu", k), {alu_opcode1, alu_a1, alu_b1}, 12'h356);
            check($sformatf("bp%0d_req_ready", k), req_ready1, 2'b00);
            check($sformatf("bp%0d_busy", k), busy1, 1);
            @(negedge clk);
        end
        rsp_ready1 = 1'b1; req_valid1 = 2'b00;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        exp_cnt1 = exp_cnt1 + 8'd1;
        check("bp_done_valid", rsp_valid1, 0);
        check("bp_op_count", op_count1, exp_cnt1);

        // ---- SETTLE_CYCLES=3: ALU output settles 2 cycles after the operands ----
        req0_opcode2 = 4'd6; req0_a2 = 4'd2; req0_b2 = 4'd3;
        alu_out2 = 4'hA; alu_flags2 = 4'hF;
        req_valid2 = 2'b01;
        @(negedge clk);                              // after E0
        req_valid2 = 2'b00;
        check("s3_alu", {alu_opcode2, alu_a2, alu_b2}, 12'h623);
        check("s3_busy", busy2, 1);
        @(negedge clk);                              // after E0+1
        check("s3_valid_e1", rsp_valid2, 0);
        @(negedge clk);                              // after E0+2
        check("s3_valid_e2", rsp_valid2, 0);
        alu_out2 = 4'h5; alu_flags2 = 4'b0100;
        @(negedge clk);                              // after E0+3
        check("s3_rsp_valid", rsp_valid2, 1);
        check("s3_rsp_out", rsp_out2, 4'h5);
        check("s3_rsp_flags", rsp_flags2, 4'b0100);
        check("s3_rsp_id", rsp_id2, 0);
        rsp_ready2 = 1'b1;
        @(negedge clk);
        rsp_ready2 = 1'b0;
        check("s3_op_count", op_count2, 1);

        // ---- reset during ISSUE aborts the operation (last grant is 0 before reset) ----
        req_valid2 = 2'b01;
        @(negedge clk);
        req_valid2 = 2'b11;
        check("ab_busy", busy2, 1);
        rst2 = 1'b1;
        #1;
        check("ab_alu", {alu_opcode2, alu_a2, alu_b2}, 12'h000);
        check("ab_rsp", {rsp_valid2, rsp_id2, rsp_out2, rsp_flags2}, 0);
        check("ab_busy_rst", busy2, 0);
        check("ab_op_count", op_count2, 0);
        check("ab_req_ready", req_ready2, 2'b00);
        req_valid2 = 2'b00;
        @(negedge clk);
        rst2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("ab%0d_no_rsp", k), rsp_valid2, 0);
        end
        req_valid2 = 2'b11;
        #1 check("ab_tie_grant", req_ready2, 2'b01);
        req_valid2 = 2'b00;

        // ---- 256 back-to-back operations wrap op_count ----
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        check("wr_start_count", op_count1, 0);
        req0_opcode1 = 4'd3; req0_a1 = 4'd5; req0_b1 = 4'd6;
        req_valid1 = 2'b01; rsp_ready1 = 1'b1;
        n = 0;
        for (int c = 0; c < 1000 && n < 256; c++) begin
            @(negedge clk);
            if (rsp_valid1) begin
                n++;
                if (n == 1) check("wr_first_count", op_count1, 0);
                if (n == 256) begin
                    check("wr_count_255", op_count1, 255);
                    req_valid1 = 2'b00;
                end
            end
        end
        check("wr_responses", n, 256);
        @(negedge clk);
        rsp_ready1 = 1'b0;
        check("wr_wrapped", op_count1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU (`ALU_4bit`). It accepts one operation at a time from either requester port over a valid/ready handshake, using round-robin priority, and drives registered opcode and operands into the ALU. It waits a programmable settle time, captures the 4-bit result and the Z/C/V/P flags, and returns them, tagged with the requester ID, on a single response channel with backpressure. It sits between the requester logic and `ALU_4bit`, so the combinational datapath is never driven by two sources at once.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before the result is captured; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester valid; bit i is requester i.
- `req_ready`  out  2  per-requester ready; a transfer occurs on a rising edge where both valid and ready are high.
- `req0_opcode`, `req1_opcode`  in  4 each  ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  4 each  ALU operands.
- `alu_opcode`, `alu_a`, `alu_b`  out  4 each  registered drive to the ALU.
- `alu_out`  in  4  ALU result.
- `alu_flags`  in  4  ALU flags as {P,V,C,Z}.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response ready.
- `rsp_id`  out  1  requester the response belongs to.
- `rsp_out`  out  4  captured ALU result.
- `rsp_flags`  out  4  captured flags, {P,V,C,Z}.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  8  completed responses; wraps 255 -> 0.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - ISSUE: ALU inputs held for `SETTLE_CYCLES` cycles.
  - RESP: response held until accepted.
- Grant is combinational in IDLE only:
  - Exactly one `req_valid` bit high: that requester wins.
  - Both high: the requester that is not `last_grant` wins.
  - `req_ready[i]` = IDLE and winner == i. Both ready bits are 0 outside IDLE.
  - `req_ready` never has two bits high.
- IDLE -> ISSUE on a transfer:
  - Register the winner's opcode, A and B into `alu_opcode`, `alu_a`, `alu_b`.
  - Set `last_grant` to the winner and latch it as `rsp_id`.
  - Load the settle counter with `SETTLE_CYCLES`-1.
- ISSUE:
  - `alu_*` held constant; counter decrements each cycle.
  - On the edge where the counter is 0: capture `alu_out` into `rsp_out` and `alu_flags` into `rsp_flags`, set `rsp_valid`, go to RESP.
- RESP:
  - Outputs held stable while `rsp_valid` is high and `rsp_ready` is low.
  - On `rsp_valid` & `rsp_ready`: clear `rsp_valid`, increment `op_count` (mod 256), go to IDLE.
- `alu_*` keep their last values in IDLE and RESP; there is no bus-idle zeroing.
- Opcode is passed through unchanged; the arbiter does not decode or check it.
- Requesters must hold valid and payload stable until ready. A payload change without a transfer has no effect.

## Timing
- Reset values: state IDLE, `req_ready` 0 during reset, `alu_opcode`/`alu_a`/`alu_b` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_out` 0, `rsp_flags` 0, `busy` 0, `op_count` 0, `last_grant` 1 (requester 0 wins the first tie).
- Accept at edge E0. `alu_*` are valid after E0. Capture happens at edge E0+`SETTLE_CYCLES`, so `rsp_valid` is high from E0+`SETTLE_CYCLES`.
- Response accepted at edge E1 returns the FSM to IDLE after E1. The next accept is at E1+1 at the earliest.
- Throughput with `rsp_ready` tied high: one operation per `SETTLE_CYCLES`+2 cycles.
- A `req_valid` drop before transfer is legal and causes no grant change.
- `last_grant` updates only on a transfer, never on a request that is withdrawn.
- Reset asserted mid-operation: the FSM aborts immediately with no response, and all outputs take their reset values asynchronously.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Test plan
- Requester 0 only, opcode 0100, A=3, B=4, ALU model returns out=7, flags=0000, `SETTLE_CYCLES`=1 -> `alu_opcode`=0100, `alu_a`=3, `alu_b`=4 after accept; `rsp_valid` one edge later with `rsp_id`=0, `rsp_out`=7, `rsp_flags`=0000; `op_count`=1.
- Both requesters valid continuously for 4 operations -> grant order 0,1,0,1; `rsp_id` sequence 0,1,0,1; `req_ready` never 2'b11.
- `rsp_ready` held low for 5 cycles after `rsp_valid` -> `rsp_*` and `alu_*` stable; `req_ready`=00; `busy`=1 throughout; completion on `rsp_ready`.
- `SETTLE_CYCLES`=3; ALU model output changes 2 cycles after the operands are driven -> the captured value is the one present at edge E0+3.
- Assert `rst` for one cycle during ISSUE -> `rsp_valid` stays 0; all outputs are 0; the next tie grants requester 0.
- 256 back-to-back operations -> `op_count` wraps to 0 after the 256th response.
